// File: rtl/p405s_cache_tag_ram.sv
// p405s_cache_tag_ram: synchronous-read cache tag RAM with per-bit write enables and an invalidate sweep
module p405s_cache_tag_ram #(
  parameter int WIDTH = 48,
  parameter int AW = 8,
  parameter logic [0:WIDTH-1] INV_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CEN,
  input  logic [0:WIDTH-1] WEN,
  input  logic [0:AW-1]    A,
  input  logic [0:WIDTH-1] D,
  input  logic             INV_REQ,
  output logic [0:WIDTH-1] Q,
  output logic             RD_VLD,
  output logic             BUSY,
  output logic             INV_DONE
);
  localparam int DEPTH = 2 ** AW;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] sc;
  logic [0:WIDTH-1] mem [DEPTH];
  logic [0:WIDTH-1] rd, wr;
  logic acc, last;
  assign BUSY = state == SWEEP;
  assign acc = ~CEN & ~BUSY;
  assign last = BUSY & (&sc);
  assign rd = mem[A];
  assign wr = (rd & WEN) | (D & ~WEN);
  always_comb state_nxt = BUSY ? (last ? IDLE : SWEEP) : (INV_REQ ? SWEEP : IDLE);
  always_ff @(posedge CLK)
    if (RST) begin
      state <= SWEEP;
      sc <= '0;
      Q <= '0;
      RD_VLD <= 1'b0;
      INV_DONE <= 1'b0;
    end else begin
      state <= state_nxt;
      sc <= BUSY ? sc + 1'b1 : '0;
      RD_VLD <= acc;
      INV_DONE <= last;
      if (acc) Q <= wr;
    end
  always_ff @(posedge CLK)
    if (!RST) begin
      if (BUSY) mem[sc] <= INV_VAL;
      else if (acc) mem[A] <= wr;
    end
endmodule

// File: tb/tb_p405s_cache_tag_ram.sv
// tb_p405s_cache_tag_ram: scoreboard bench for a 48x256 and a 22x64 tag RAM
module tb_p405s_cache_tag_ram;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst0 = 1, rst1 = 1, cen0 = 1, cen1 = 1, inv0 = 0, inv1 = 0;
  logic [47:0] wen = '1, d = '0;
  logic [7:0] a = '0;
  logic [47:0] q0;
  logic [21:0] q1;
  logic vld0, vld1, busy0, busy1, done0, done1;
  int vecs = 0, errs = 0;
  logic [47:0] sb0 [$];
  logic [47:0] sb1 [$];

  p405s_cache_tag_ram u0 (
    .CLK(clk), .RST(rst0), .CEN(cen0), .WEN(wen), .A(a), .D(d), .INV_REQ(inv0),
    .Q(q0), .RD_VLD(vld0), .BUSY(busy0), .INV_DONE(done0)
  );
  p405s_cache_tag_ram #(.WIDTH(22), .AW(6)) u1 (
    .CLK(clk), .RST(rst1), .CEN(cen1), .WEN(wen[21:0]), .A(a[5:0]), .D(d[21:0]), .INV_REQ(inv1),
    .Q(q1), .RD_VLD(vld1), .BUSY(busy1), .INV_DONE(done1)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [47:0] mask(int sel);
    return sel != 0 ? 48'h3F_FFFF : '1;
  endfunction
  function automatic logic bsy(int sel);
    return sel != 0 ? busy1 : busy0;
  endfunction
  function automatic logic dn(int sel);
    return sel != 0 ? done1 : done0;
  endfunction
  function automatic logic rv(int sel);
    return sel != 0 ? vld1 : vld0;
  endfunction
  function automatic logic [47:0] qv(int sel);
    return sel != 0 ? {26'b0, q1} : q0;
  endfunction

  task automatic set_cen(int sel, logic v);
    if (sel != 0) cen1 = v; else cen0 = v;
  endtask
  task automatic set_inv(int sel, logic v);
    if (sel != 0) inv1 = v; else inv0 = v;
  endtask
  task automatic set_rst(int sel, logic v);
    if (sel != 0) rst1 = v; else rst0 = v;
  endtask

  always @(negedge clk) begin
    if (vld0) begin
      if (sb0.size() == 0) chk("u0 spurious rd_vld", 1, 0);
      else chk("u0 q", q0, sb0.pop_front());
    end
    if (vld1) begin
      if (sb1.size() == 0) chk("u1 spurious rd_vld", 1, 0);
      else chk("u1 q", {26'b0, q1}, sb1.pop_front());
    end
  end

  task automatic acc(int sel, logic [7:0] aa, logic [47:0] ww, logic [47:0] dd, logic [47:0] ee, logic iv = 0);
    a = aa; wen = ww; d = dd;
    set_cen(sel, 0);
    set_inv(sel, iv);
    if (sel != 0) sb1.push_back(ee & mask(sel)); else sb0.push_back(ee);
    @(posedge clk); #1;
    set_cen(sel, 1);
    set_inv(sel, 0);
  endtask

  // With poke set, dropped writes and a second INV_REQ are injected mid-sweep
  task automatic wait_sweep(int sel, int len, bit poke);
    int n = 0;
    logic [47:0] q_hold = qv(sel);
    @(negedge clk);
    while (bsy(sel) && n < 2000) begin
      n++;
      if (poke) begin
        if (n >= 11 && n <= 15) begin
          chk("drop rd_vld", rv(sel), 0);
          chk("drop q", qv(sel), q_hold);
        end
        set_cen(sel, !(n >= 10 && n <= 13));
        set_inv(sel, n == 20);
        wen = '0; d = 48'hDEAD_BEEF_CAFE; a = 8'(n - 5);
      end
      @(negedge clk);
    end
    set_cen(sel, 1);
    set_inv(sel, 0);
    chk("busy length", n, len);
    chk("inv_done", dn(sel), 1);
    @(negedge clk);
    chk("inv_done pulse", dn(sel), 0);
  endtask

  task automatic suite(int sel);
    int dep = sel != 0 ? 64 : 256;
    int rst_at = sel != 0 ? 40 : 100;
    set_rst(sel, 1);
    repeat (2) @(posedge clk);
    #1 chk("busy in reset", bsy(sel), 1);
    set_rst(sel, 0);
    wait_sweep(sel, dep, 0);
    acc(sel, 8'd0, '1, '0, '0);
    acc(sel, 8'(dep / 2 - 1), '1, '0, '0);
    acc(sel, 8'(dep - 1), '1, '0, '0);
    acc(sel, 8'h12, 48'h0000_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_0000_0000);
    acc(sel, 8'h12, '1, '0, 48'hFFFF_0000_0000);
    acc(sel, 8'h13, '1, '0, '0);
    acc(sel, 8'd5, '0, 48'hA5A5_0000_1234, 48'hA5A5_0000_1234);
    acc(sel, 8'd5, '1, '0, 48'hA5A5_0000_1234);
    acc(sel, 8'd5, 48'hFF00_FF00_FF00, 48'h0F0F_0F0F_0F0F, 48'hA50F_000F_120F);
    acc(sel, 8'd5, '1, '0, 48'hA50F_000F_120F);
    for (int i = 0; i < 4; i++) acc(sel, 8'(i), '0, 48'h1111_2222_0000 + 48'(i), 48'h1111_2222_0000 + 48'(i));
    acc(sel, 8'd3, '0, 48'hBEEF_0000_0003, 48'hBEEF_0000_0003, 1);
    wait_sweep(sel, dep, 0);
    for (int i = 0; i < 4; i++) acc(sel, 8'(i), '1, '0, '0);
    acc(sel, 8'd5, '1, '0, '0);
    acc(sel, 8'd9, '0, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 1);
    wait_sweep(sel, dep, 1);
    for (int i = 5; i < 9; i++) acc(sel, 8'(i), '1, '0, '0);
    acc(sel, 8'd0, '1, '0, '0, 1);
    repeat (rst_at) @(posedge clk);
    #1 set_rst(sel, 1);
    @(posedge clk);
    #1 set_rst(sel, 0);
    wait_sweep(sel, dep, 0);
    acc(sel, 8'd0, '1, '0, '0);
    repeat (3) @(posedge clk);
    chk("scoreboard drained", sel != 0 ? sb1.size() : sb0.size(), 0);
  endtask

  initial begin
    suite(0);
    suite(1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
